// File: rtl/vrf_write_responder_if.sv
// Stage-3 VRF write channel bundle: write beats, lane read port and completion report.
// The master side is the issuer of write beats and reads; the slave side is the lane responder.
interface vrf_write_responder_if #(
  parameter int VD_WIDTH     = 5,
  parameter int OFFSET_WIDTH = 7,
  parameter int DATA_WIDTH   = 32,
  parameter int INST_WIDTH   = 3,
  parameter int COUNT_WIDTH  = 11
);
  logic                      vrfWriteRequest_valid;
  logic                      vrfWriteRequest_ready;
  logic [VD_WIDTH-1:0]       vrfWriteRequest_bits_vd;
  logic [OFFSET_WIDTH-1:0]   vrfWriteRequest_bits_offset;
  logic [DATA_WIDTH/8-1:0]   vrfWriteRequest_bits_mask;
  logic [DATA_WIDTH-1:0]     vrfWriteRequest_bits_data;
  logic                      vrfWriteRequest_bits_last;
  logic [INST_WIDTH-1:0]     vrfWriteRequest_bits_instructionIndex;

  logic                      readRequest_valid;
  logic [VD_WIDTH-1:0]       readRequest_vd;
  logic [OFFSET_WIDTH-1:0]   readRequest_offset;
  logic                      readResult_valid;
  logic [DATA_WIDTH-1:0]     readResult_data;

  logic                      writeDone_valid;
  logic [INST_WIDTH-1:0]     writeDone_instructionIndex;
  logic [COUNT_WIDTH-1:0]    writeDone_count;

  modport master (
    output vrfWriteRequest_valid,
    input  vrfWriteRequest_ready,
    output vrfWriteRequest_bits_vd,
    output vrfWriteRequest_bits_offset,
    output vrfWriteRequest_bits_mask,
    output vrfWriteRequest_bits_data,
    output vrfWriteRequest_bits_last,
    output vrfWriteRequest_bits_instructionIndex,
    output readRequest_valid,
    output readRequest_vd,
    output readRequest_offset,
    input  readResult_valid,
    input  readResult_data,
    input  writeDone_valid,
    input  writeDone_instructionIndex,
    input  writeDone_count
  );

  modport slave (
    input  vrfWriteRequest_valid,
    output vrfWriteRequest_ready,
    input  vrfWriteRequest_bits_vd,
    input  vrfWriteRequest_bits_offset,
    input  vrfWriteRequest_bits_mask,
    input  vrfWriteRequest_bits_data,
    input  vrfWriteRequest_bits_last,
    input  vrfWriteRequest_bits_instructionIndex,
    input  readRequest_valid,
    input  readRequest_vd,
    input  readRequest_offset,
    output readResult_valid,
    output readResult_data,
    output writeDone_valid,
    output writeDone_instructionIndex,
    output writeDone_count
  );
endinterface

// File: rtl/vrf_write_responder.sv
// Lane-side VRF write responder: one-stage byte-masked write pipeline, forwarding read port,
// and per-instruction commit counters that report completion when the last beat commits.
module vrf_write_responder #(
  parameter int VD_WIDTH     = 5,
  parameter int OFFSET_WIDTH = 7,
  parameter int DATA_WIDTH   = 32,
  parameter int INST_WIDTH   = 3,
  parameter int COUNT_WIDTH  = 11
) (
  input logic                  clock,
  input logic                  reset,
  vrf_write_responder_if.slave bus
);
  localparam int ADDR_WIDTH = VD_WIDTH + OFFSET_WIDTH;
  localparam int MASK_WIDTH = DATA_WIDTH / 8;
  localparam int DEPTH      = 1 << ADDR_WIDTH;
  localparam int INST_COUNT = 1 << INST_WIDTH;
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = {COUNT_WIDTH{1'b1}};

  function automatic logic [DATA_WIDTH-1:0] mergeBytes(
    input logic [DATA_WIDTH-1:0] oldWord,
    input logic [DATA_WIDTH-1:0] newWord,
    input logic [MASK_WIDTH-1:0] byteMask
  );
    logic [DATA_WIDTH-1:0] merged;
    merged = oldWord;
    for (int i = 0; i < MASK_WIDTH; i++) begin
      merged[8*i +: 8] = byteMask[i] ? newWord[8*i +: 8] : oldWord[8*i +: 8];
    end
    return merged;
  endfunction

  function automatic logic [COUNT_WIDTH-1:0] satInc(input logic [COUNT_WIDTH-1:0] value);
    return (value == COUNT_MAX) ? COUNT_MAX : value + COUNT_WIDTH'(1);
  endfunction

  logic [DATA_WIDTH-1:0]  vrf_r [DEPTH];
  logic [COUNT_WIDTH-1:0] cnt_r [INST_COUNT];

  logic                   s1Valid_r;
  logic [ADDR_WIDTH-1:0]  s1Addr_r;
  logic [MASK_WIDTH-1:0]  s1Mask_r;
  logic [DATA_WIDTH-1:0]  s1Data_r;
  logic                   s1Last_r;
  logic [INST_WIDTH-1:0]  s1Idx_r;

  logic                   readValid_r;
  logic [DATA_WIDTH-1:0]  readData_r;
  logic                   doneValid_r;
  logic [INST_WIDTH-1:0]  doneIdx_r;
  logic [COUNT_WIDTH-1:0] doneCount_r;

  logic                   accept_s;
  logic [ADDR_WIDTH-1:0]  readAddr_s;
  logic                   readHit_s;
  logic [DATA_WIDTH-1:0]  readWord_s;
  logic [COUNT_WIDTH-1:0] commitCount_s;

  // Reads own the cycle; a write beat is only taken when no read is strobed.
  assign bus.vrfWriteRequest_ready = ~reset & ~bus.readRequest_valid;
  assign accept_s = bus.vrfWriteRequest_valid & bus.vrfWriteRequest_ready;

  // The staged beat is not yet in the array, so a matching read merges its enabled bytes.
  assign readAddr_s    = {bus.readRequest_vd, bus.readRequest_offset};
  assign readHit_s     = s1Valid_r & (s1Addr_r == readAddr_s);
  assign readWord_s    = mergeBytes(vrf_r[readAddr_s], s1Data_r,
                                    readHit_s ? s1Mask_r : {MASK_WIDTH{1'b0}});
  assign commitCount_s = satInc(cnt_r[s1Idx_r]);

  // Stage S1: capture the accepted beat for commit on the following edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1Valid_r <= 1'b0;
      s1Addr_r  <= {ADDR_WIDTH{1'b0}};
      s1Mask_r  <= {MASK_WIDTH{1'b0}};
      s1Data_r  <= {DATA_WIDTH{1'b0}};
      s1Last_r  <= 1'b0;
      s1Idx_r   <= {INST_WIDTH{1'b0}};
    end else begin
      s1Valid_r <= accept_s;
      if (accept_s) begin
        s1Addr_r <= {bus.vrfWriteRequest_bits_vd, bus.vrfWriteRequest_bits_offset};
        s1Mask_r <= bus.vrfWriteRequest_bits_mask;
        s1Data_r <= bus.vrfWriteRequest_bits_data;
        s1Last_r <= bus.vrfWriteRequest_bits_last;
        s1Idx_r  <= bus.vrfWriteRequest_bits_instructionIndex;
      end else begin
        s1Last_r <= s1Last_r;
      end
    end
  end

  // VRF slice storage: byte-masked commit of the staged beat; contents survive reset.
  always_ff @(posedge clock) begin
    if (s1Valid_r) begin
      vrf_r[s1Addr_r] <= mergeBytes(vrf_r[s1Addr_r], s1Data_r, s1Mask_r);
    end
  end

  // Read port: result and its valid appear one cycle after the strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      readValid_r <= 1'b0;
      readData_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      readValid_r <= bus.readRequest_valid;
      if (bus.readRequest_valid) begin
        readData_r <= readWord_s;
      end else begin
        readData_r <= readData_r;
      end
    end
  end

  // Per-instruction commit counters and the completion pulse for last-flagged beats.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < INST_COUNT; i++) begin
        cnt_r[i] <= {COUNT_WIDTH{1'b0}};
      end
      doneValid_r <= 1'b0;
      doneIdx_r   <= {INST_WIDTH{1'b0}};
      doneCount_r <= {COUNT_WIDTH{1'b0}};
    end else begin
      doneValid_r <= 1'b0;
      if (s1Valid_r) begin
        if (s1Last_r) begin
          doneValid_r    <= 1'b1;
          doneIdx_r      <= s1Idx_r;
          doneCount_r    <= commitCount_s;
          cnt_r[s1Idx_r] <= {COUNT_WIDTH{1'b0}};
        end else begin
          cnt_r[s1Idx_r] <= commitCount_s;
        end
      end else begin
        doneIdx_r <= doneIdx_r;
      end
    end
  end

  assign bus.readResult_valid           = readValid_r;
  assign bus.readResult_data            = readData_r;
  assign bus.writeDone_valid            = doneValid_r;
  assign bus.writeDone_instructionIndex = doneIdx_r;
  assign bus.writeDone_count            = doneCount_r;
endmodule

// File: tb/tb_vrf_write_responder.sv
// Scoreboard bench for vrf_write_responder: a word-level memory and per-instruction beat
// tally predict every read result and completion report, checked by an independent monitor.
module tb_vrf_write_responder;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  vrf_write_responder_if bus ();
  vrf_write_responder dut (.clock(clock), .reset(reset), .bus(bus));

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } readExp_t;

  typedef struct {
    logic [2:0]  idx;
    logic [10:0] count;
    int          cyc;
  } doneExp_t;

  readExp_t    readQ[$];
  doneExp_t    doneQ[$];
  logic [31:0] mem [4096];
  int          tally [8];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [4:0]  poolVd [8];
  logic [6:0]  poolOff [8];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle of stimulus; the reference memory reflects every beat accepted before a read.
  task automatic drive(input logic wv, input logic [4:0] vd, input logic [6:0] off,
                       input logic [3:0] mask, input logic [31:0] data, input logic last,
                       input logic [2:0] idx, input logic rv, input logic [4:0] rvd,
                       input logic [6:0] roff, input bit modelOn);
    readExp_t re;
    doneExp_t de;
    logic [11:0] a;
    int next;
    @(negedge clock);
    bus.vrfWriteRequest_valid                 = wv;
    bus.vrfWriteRequest_bits_vd               = vd;
    bus.vrfWriteRequest_bits_offset           = off;
    bus.vrfWriteRequest_bits_mask             = mask;
    bus.vrfWriteRequest_bits_data             = data;
    bus.vrfWriteRequest_bits_last             = last;
    bus.vrfWriteRequest_bits_instructionIndex = idx;
    bus.readRequest_valid                     = rv;
    bus.readRequest_vd                        = rvd;
    bus.readRequest_offset                    = roff;
    if (rv) begin
      re.data = mem[{rvd, roff}];
      re.cyc  = cyc + 1;
      readQ.push_back(re);
    end else if (wv && modelOn) begin
      a = {vd, off};
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) mem[a][8*i +: 8] = data[8*i +: 8];
      end
      next = (tally[idx] + 1 > 2047) ? 2047 : tally[idx] + 1;
      if (last) begin
        de.idx   = idx;
        de.count = 11'(next);
        de.cyc   = cyc + 2;
        doneQ.push_back(de);
        tally[idx] = 0;
      end else begin
        tally[idx] = next;
      end
    end
    #1;
    check("ready", 64'(bus.vrfWriteRequest_ready), 64'(!rv));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 5'd0, 7'd0, 4'h0, 32'h0, 1'b0, 3'd0, 1'b0, 5'd0, 7'd0, 1'b1);
  endtask

  task automatic wr(input logic [4:0] vd, input logic [6:0] off, input logic [3:0] mask,
                    input logic [31:0] data, input logic last, input logic [2:0] idx);
    drive(1'b1, vd, off, mask, data, last, idx, 1'b0, 5'd0, 7'd0, 1'b1);
  endtask

  task automatic rd(input logic [4:0] vd, input logic [6:0] off);
    drive(1'b0, 5'd0, 7'd0, 4'h0, 32'h0, 1'b0, 3'd0, 1'b1, vd, off, 1'b1);
  endtask

  task automatic checkOutputsZero(input string tag);
    check({tag, "_ready"}, 64'(bus.vrfWriteRequest_ready), 64'd0);
    check({tag, "_rdValid"}, 64'(bus.readResult_valid), 64'd0);
    check({tag, "_rdData"}, 64'(bus.readResult_data), 64'd0);
    check({tag, "_doneValid"}, 64'(bus.writeDone_valid), 64'd0);
    check({tag, "_doneIdx"}, 64'(bus.writeDone_instructionIndex), 64'd0);
    check({tag, "_doneCount"}, 64'(bus.writeDone_count), 64'd0);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a result, and flags overdue ones.
  initial begin : monitor
    readExp_t re;
    doneExp_t de;
    forever begin
      @(posedge clock);
      #1;
      if (!reset) begin
        if (bus.readResult_valid) begin
          if (readQ.size() == 0) begin
            check("readUnexpected", 64'd1, 64'd0);
          end else begin
            re = readQ.pop_front();
            check("readData", 64'(bus.readResult_data), 64'(re.data));
            check("readCycle", 64'(cyc), 64'(re.cyc));
          end
        end else if (readQ.size() > 0 && readQ[0].cyc <= cyc) begin
          re = readQ.pop_front();
          check("readMissing", 64'd0, 64'd1);
        end
        if (bus.writeDone_valid) begin
          if (doneQ.size() == 0) begin
            check("doneUnexpected", 64'd1, 64'd0);
          end else begin
            de = doneQ.pop_front();
            check("doneIdx", 64'(bus.writeDone_instructionIndex), 64'(de.idx));
            check("doneCount", 64'(bus.writeDone_count), 64'(de.count));
            check("doneCycle", 64'(cyc), 64'(de.cyc));
          end
        end else if (doneQ.size() > 0 && doneQ[0].cyc <= cyc) begin
          de = doneQ.pop_front();
          check("doneMissing", 64'd0, 64'd1);
        end
      end
    end
  end

  initial begin : stimulus
    logic [31:0] rnd;
    int a;
    int b;
    bus.vrfWriteRequest_valid = 1'b0;
    bus.vrfWriteRequest_bits_vd = 5'd0;
    bus.vrfWriteRequest_bits_offset = 7'd0;
    bus.vrfWriteRequest_bits_mask = 4'h0;
    bus.vrfWriteRequest_bits_data = 32'h0;
    bus.vrfWriteRequest_bits_last = 1'b0;
    bus.vrfWriteRequest_bits_instructionIndex = 3'd0;
    bus.readRequest_valid = 1'b0;
    bus.readRequest_vd = 5'd0;
    bus.readRequest_offset = 7'd0;
    for (int i = 0; i < 8; i++) tally[i] = 0;

    #1 reset = 1'b1;
    #1 checkOutputsZero("reset");
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Full write, plain read, then a partial write read back through forwarding.
    wr(5'd3, 7'd5, 4'hF, 32'hA5A5_A5A5, 1'b0, 3'd0);
    idle(1);
    rd(5'd3, 7'd5);
    idle(1);
    wr(5'd3, 7'd5, 4'h2, 32'h0000_3C00, 1'b0, 3'd0);
    rd(5'd3, 7'd5);
    idle(1);

    // Read strobe held against a waiting write: the write lands only afterwards.
    for (int i = 0; i < 3; i++)
      drive(1'b1, 5'd4, 7'd9, 4'hF, 32'h1234_5678, 1'b0, 3'd0, 1'b1, 5'd3, 7'd5, 1'b1);
    wr(5'd4, 7'd9, 4'hF, 32'h1234_5678, 1'b0, 3'd0);
    idle(1);
    rd(5'd4, 7'd9);
    wr(5'd4, 7'd9, 4'h0, 32'hFFFF_FFFF, 1'b0, 3'd0);
    rd(5'd4, 7'd9);

    // Four back-to-back beats on idx 2, then one more to show the counter restarted.
    for (int i = 0; i < 4; i++) wr(5'd7, 7'(i), 4'hF, 32'(i * 17), (i == 3), 3'd2);
    wr(5'd7, 7'd4, 4'hF, 32'hCAFE_0001, 1'b1, 3'd2);
    idle(2);

    // Interleaved instructions 1 and 6.
    wr(5'd8, 7'd0, 4'h1, 32'h11, 1'b0, 3'd1);
    wr(5'd8, 7'd1, 4'h3, 32'h66, 1'b0, 3'd6);
    wr(5'd8, 7'd2, 4'h7, 32'h111, 1'b0, 3'd1);
    wr(5'd8, 7'd3, 4'hF, 32'h666, 1'b1, 3'd6);
    wr(5'd8, 7'd4, 4'h8, 32'h1111, 1'b1, 3'd1);
    idle(3);

    // Counter saturation on idx 5.
    for (int i = 0; i < 2050; i++) wr(5'd30, 7'(i % 128), 4'hF, $urandom, 1'b0, 3'd5);
    wr(5'd30, 7'd0, 4'hF, 32'h5A5A_0000, 1'b1, 3'd5);
    idle(3);

    // Random traffic over a small pool of initialised addresses.
    for (int i = 0; i < 8; i++) begin
      poolVd[i]  = 5'(i * 3 + 1);
      poolOff[i] = 7'(i * 11);
      wr(poolVd[i], poolOff[i], 4'hF, $urandom, 1'b0, 3'(i));
    end
    for (int n = 0; n < 800; n++) begin
      a = $urandom_range(0, 7);
      b = $urandom_range(0, 7);
      rnd = $urandom;
      drive(($urandom_range(0, 3) != 0), poolVd[a], poolOff[a], rnd[3:0], $urandom,
            ($urandom_range(0, 5) == 0), rnd[6:4], ($urandom_range(0, 3) == 0),
            poolVd[b], poolOff[b], 1'b1);
    end
    idle(4);
    check("readQueueDrained", 64'(readQ.size()), 64'd0);
    check("doneQueueDrained", 64'(doneQ.size()), 64'd0);

    // Reset while a last beat is staged: it must never commit or report.
    drive(1'b1, 5'd3, 7'd5, 4'hF, 32'hDEAD_BEEF, 1'b1, 3'd0, 1'b0, 5'd0, 7'd0, 1'b0);
    @(negedge clock);
    bus.vrfWriteRequest_valid = 1'b0;
    reset = 1'b1;
    #1 checkOutputsZero("midReset");
    for (int i = 0; i < 8; i++) tally[i] = 0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    rd(5'd3, 7'd5);
    for (int i = 0; i < 8; i++) wr(5'd9, 7'(i), 4'hF, 32'(i), 1'b1, 3'(i));
    idle(4);
    check("readQueueFinal", 64'(readQ.size()), 64'd0);
    check("doneQueueFinal", 64'(doneQ.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
